// File: rtl/ahb_mon_pkg.sv
// Shared types, check ids and burst address helpers for the AHB-Lite protocol monitor.
// Optional feature macro: AHB_MON_XCHK_EN adds the X_DATA check (id 5, NCHK = 6).
package ahb_mon_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic {
    B_IDLE   = 1'b0,
    B_ACTIVE = 1'b1
  } burst_state_e;

  localparam int CHK_TIMEOUT      = 0;
  localparam int CHK_SEQ_NO_BURST = 1;
  localparam int CHK_ADDR_SEQ     = 2;
  localparam int CHK_CTRL_STABLE  = 3;
  localparam int CHK_BURST_LEN    = 4;
  localparam int CHK_XDATA        = 5;

`ifdef AHB_MON_XCHK_EN
  localparam int NCHK = 6;
`else
  localparam int NCHK = 5;
`endif

  // Widest address the helpers handle; callers zero-extend and truncate.
  localparam int AW_MAX = 64;

  // Beats in a defined-length burst; 0 means unbounded (INCR) or SINGLE.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    case (hburst)
      HB_WRAP4, HB_INCR4:   return 5'd4;
      HB_WRAP8, HB_INCR8:   return 5'd8;
      HB_WRAP16, HB_INCR16: return 5'd16;
      default:              return 5'd0;
    endcase
  endfunction

  // Address of the beat following addr. Wrapping bursts keep the bits above
  // the n*(1<<hsize) boundary and let the low bits roll over; for incrementing
  // bursts the mask is all-ones so this reduces to addr + bytes.
  function automatic logic [AW_MAX-1:0] next_addr(input logic [AW_MAX-1:0] addr,
                                                  input logic [2:0] hsize,
                                                  input logic [2:0] hburst);
    logic [AW_MAX-1:0] bytes;
    logic [AW_MAX-1:0] mask;
    bytes = AW_MAX'(1) << hsize;
    case (hburst)
      HB_WRAP4:  mask = (bytes << 2) - AW_MAX'(1);
      HB_WRAP8:  mask = (bytes << 3) - AW_MAX'(1);
      HB_WRAP16: mask = (bytes << 4) - AW_MAX'(1);
      default:   mask = '1;
    endcase
    return (addr & ~mask) | ((addr + bytes) & mask);
  endfunction

endpackage

// File: rtl/ahb_mon_burst_tracker.sv
// Burst state tracker: follows accepted address phases, counts beats, predicts
// the next SEQ address and raises the burst-related checks combinationally.
// Ports: clk/resetn; AHB address-phase inputs hsel, htrans, hsize, hburst,
// haddr, hready; burst_state (FSM state, debug), beat_cnt; chk_seq_no_burst,
// chk_addr_seq, chk_burst_len (combinational violation strobes).
module ahb_mon_burst_tracker
  import ahb_mon_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hready,
  output burst_state_e      burst_state,
  output logic [4:0]        beat_cnt,
  output logic              chk_seq_no_burst,
  output logic              chk_addr_seq,
  output logic              chk_burst_len
);

  burst_state_e      state_q, state_d;
  logic [4:0]        beat_cnt_q, beat_cnt_d;
  logic [4:0]        len_q, len_d;
  logic [2:0]        burst_q, burst_d;
  logic [2:0]        size_q, size_d;
  logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
  logic              done_q, done_d;

  logic              ns_acc, seq_acc, busy_acc, idle_acc;
  logic [AW_MAX-1:0] addr_ext, exp_ext, nxt_a, nxt_e;
  logic              unused_nxt;

  assign unused_nxt = ^{nxt_a, nxt_e};

  always_comb begin
    addr_ext = '0;
    addr_ext[ADDR_W-1:0] = haddr;
    exp_ext = '0;
    exp_ext[ADDR_W-1:0] = exp_addr_q;
    nxt_a = next_addr(addr_ext, hsize, hburst);
    nxt_e = next_addr(exp_ext, size_q, burst_q);

    ns_acc   = hready && hsel && (htrans == HT_NONSEQ);
    seq_acc  = hready && hsel && (htrans == HT_SEQ);
    busy_acc = hready && hsel && (htrans == HT_BUSY);
    // A deselected slot counts as IDLE for this slave.
    idle_acc = hready && (!hsel || (htrans == HT_IDLE));

    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    burst_d    = burst_q;
    size_d     = size_q;
    exp_addr_d = exp_addr_q;
    // done marks "a defined burst just completed" until the next address is accepted.
    done_d     = hready ? 1'b0 : done_q;
    chk_seq_no_burst = 1'b0;
    chk_addr_seq     = 1'b0;
    chk_burst_len    = 1'b0;

    unique case (state_q)
      B_IDLE: begin
        beat_cnt_d       = '0;
        chk_seq_no_burst = seq_acc || busy_acc;
        chk_burst_len    = seq_acc && done_q;
      end
      B_ACTIVE: begin
        if (seq_acc) begin
          chk_addr_seq = (haddr != exp_addr_q);
          if (beat_cnt_q != 5'd31) beat_cnt_d = beat_cnt_q + 5'd1;
          // Continue from the predicted address so one bad beat flags once.
          exp_addr_d = nxt_e[ADDR_W-1:0];
          if ((len_q != 5'd0) && (beat_cnt_q + 5'd1 == len_q)) begin
            state_d = B_IDLE;
            done_d  = 1'b1;
          end
        end else if (ns_acc || idle_acc) begin
          // Still active means a defined burst has not reached its length.
          chk_burst_len = (len_q != 5'd0);
          state_d       = B_IDLE;
          beat_cnt_d    = '0;
        end
      end
    endcase

    if (ns_acc && (hburst != HB_SINGLE)) begin
      state_d    = B_ACTIVE;
      beat_cnt_d = 5'd1;
      len_d      = burst_len(hburst);
      burst_d    = hburst;
      size_d     = hsize;
      exp_addr_d = nxt_a[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= B_IDLE;
      beat_cnt_q <= '0;
      len_q      <= '0;
      burst_q    <= '0;
      size_q     <= '0;
      exp_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      size_q     <= size_d;
      exp_addr_q <= exp_addr_d;
      done_q     <= done_d;
    end
  end

  assign burst_state = state_q;
  assign beat_cnt    = beat_cnt_q;

endmodule

// File: rtl/ahb_protocol_monitor.sv
// AHB-Lite slave-side protocol monitor. Detects violations combinationally on
// the sampling cycle and reports them as registered pulses, sticky flags, the
// id of the first violation and a saturating event count.
// Handshake: an address phase is accepted when hready && hsel && htrans is
// NONSEQ or SEQ; its data phase is pending from the next cycle until hready=1.
// Ports: clk, resetn (async, active-low); AHB inputs hsel, htrans, hwrite,
// hsize, hburst, haddr, hwdata, hready; err_clear; outputs err_pulse,
// err_sticky, err_first, err_count, burst_active, beat_cnt.
// Optional feature macro: AHB_MON_XCHK_EN (X_DATA check, simulation-only).
module ahb_protocol_monitor
  import ahb_mon_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int HREADY_TIMEOUT = 16,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              err_clear,
  output logic [NCHK-1:0]   err_pulse,
  output logic [NCHK-1:0]   err_sticky,
  output logic [2:0]        err_first,
  output logic [CNT_W-1:0]  err_count,
  output logic              burst_active,
  output logic [4:0]        beat_cnt
);

  localparam int WAIT_W = $clog2(HREADY_TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] WAIT_FIRE = WAIT_W'(HREADY_TIMEOUT);
  localparam int SUM_W = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  burst_state_e burst_state;
  logic c1, c2, c4, c0, c3;

  ahb_mon_burst_tracker #(.ADDR_W(ADDR_W)) u_burst (
    .clk              (clk),
    .resetn           (resetn),
    .hsel             (hsel),
    .htrans           (htrans),
    .hsize            (hsize),
    .hburst           (hburst),
    .haddr            (haddr),
    .hready           (hready),
    .burst_state      (burst_state),
    .beat_cnt         (beat_cnt),
    .chk_seq_no_burst (c1),
    .chk_addr_seq     (c2),
    .chk_burst_len    (c4)
  );

  logic              pending_q, pending_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              ap_hold_q, ap_hold_d;
  logic [ADDR_W-1:0] ap_addr_q;
  logic              ap_write_q;
  logic [2:0]        ap_size_q, ap_burst_q;
  logic [1:0]        ap_trans_q;
  logic [NCHK-1:0]   pulse_q, sticky_q, sticky_d, det, base_sticky;
  logic [2:0]        first_q, first_d, low_id, pop;
  logic [CNT_W-1:0]  count_q, count_d, base_cnt;
  logic [SUM_W-1:0]  sum;

`ifdef AHB_MON_XCHK_EN
  logic pend_write_q, pend_write_d;
  logic c5;
  assign pend_write_d = hready ? (hready && hsel && htrans[1] && hwrite) : pend_write_q;
  assign c5 = (pend_write_q && hready && $isunknown(hwdata)) ||
              (resetn && ($isunknown(htrans) || $isunknown(hready)));
`else
  logic unused_hwdata;
  assign unused_hwdata = ^hwdata;
`endif

  always_comb begin
    pending_d = hready ? (hsel && htrans[1]) : pending_q;

    // Counts stall cycles of a pending data phase; parks one past the fire
    // value so a long stall reports only once.
    wait_cnt_d = '0;
    c0 = 1'b0;
    if (pending_q && !hready) begin
      wait_cnt_d = wait_cnt_q;
      if (wait_cnt_q <= WAIT_FIRE) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      c0 = (wait_cnt_q == WAIT_FIRE);
    end

    // Control must hold while a NONSEQ/SEQ address phase is being stalled.
    ap_hold_d = hsel && !hready && htrans[1];
    c3 = ap_hold_q && ((haddr != ap_addr_q) || (hwrite != ap_write_q) ||
                       (hsize != ap_size_q) || (hburst != ap_burst_q) ||
                       (htrans != ap_trans_q));

    det = '0;
    det[CHK_TIMEOUT]      = c0;
    det[CHK_SEQ_NO_BURST] = c1;
    det[CHK_ADDR_SEQ]     = c2;
    det[CHK_CTRL_STABLE]  = c3;
    det[CHK_BURST_LEN]    = c4;
`ifdef AHB_MON_XCHK_EN
    det[CHK_XDATA]        = c5;
`endif

    pop = '0;
    low_id = '0;
    for (int i = 0; i < NCHK; i++) pop = pop + 3'(det[i]);
    for (int i = NCHK - 1; i >= 0; i--) if (det[i]) low_id = 3'(i);

    // Clear takes effect first, then this cycle's detections are recorded.
    base_sticky = err_clear ? '0 : sticky_q;
    base_cnt    = err_clear ? '0 : count_q;
    sticky_d    = base_sticky | det;
    sum         = SUM_W'(base_cnt) + SUM_W'(pop);
    count_d     = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    first_d     = err_clear ? 3'd0 : first_q;
    if ((base_sticky == '0) && (det != '0)) first_d = low_id;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_q  <= 1'b0;
      wait_cnt_q <= '0;
      ap_hold_q  <= 1'b0;
      ap_addr_q  <= '0;
      ap_write_q <= 1'b0;
      ap_size_q  <= '0;
      ap_burst_q <= '0;
      ap_trans_q <= '0;
      pulse_q    <= '0;
      sticky_q   <= '0;
      first_q    <= '0;
      count_q    <= '0;
`ifdef AHB_MON_XCHK_EN
      pend_write_q <= 1'b0;
`endif
    end else begin
      pending_q  <= pending_d;
      wait_cnt_q <= wait_cnt_d;
      ap_hold_q  <= ap_hold_d;
      ap_addr_q  <= haddr;
      ap_write_q <= hwrite;
      ap_size_q  <= hsize;
      ap_burst_q <= hburst;
      ap_trans_q <= htrans;
      pulse_q    <= det;
      sticky_q   <= sticky_d;
      first_q    <= first_d;
      count_q    <= count_d;
`ifdef AHB_MON_XCHK_EN
      pend_write_q <= pend_write_d;
`endif
    end
  end

  assign err_pulse    = pulse_q;
  assign err_sticky   = sticky_q;
  assign err_first    = first_q;
  assign err_count    = count_q;
  assign burst_active = (burst_state == B_ACTIVE);

endmodule

// File: tb/tb_ahb_protocol_monitor.sv
module tb_ahb_protocol_monitor;
  import ahb_mon_pkg::*;

  logic            clk;
  logic            resetn;
  logic            hsel;
  logic [1:0]      htrans;
  logic            hwrite;
  logic [2:0]      hsize;
  logic [2:0]      hburst;
  logic [31:0]     haddr;
  logic [31:0]     hwdata;
  logic            hready;
  logic            err_clear;
  logic [NCHK-1:0] err_pulse;
  logic [NCHK-1:0] err_sticky;
  logic [2:0]      err_first;
  logic [7:0]      err_count;
  logic            burst_active;
  logic [4:0]      beat_cnt;

  int checks = 0;
  int errors = 0;

  ahb_protocol_monitor #(
    .ADDR_W(32), .DATA_W(32), .HREADY_TIMEOUT(16), .CNT_W(8)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .hsel         (hsel),
    .htrans       (htrans),
    .hwrite       (hwrite),
    .hsize        (hsize),
    .hburst       (hburst),
    .haddr        (haddr),
    .hwdata       (hwdata),
    .hready       (hready),
    .err_clear    (err_clear),
    .err_pulse    (err_pulse),
    .err_sticky   (err_sticky),
    .err_first    (err_first),
    .err_count    (err_count),
    .burst_active (burst_active),
    .beat_cnt     (beat_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic sel, input logic [1:0] trans, input logic wr,
                     input logic [2:0] size, input logic [2:0] burst,
                     input logic [31:0] addr, input logic rdy);
    hsel   = sel;
    htrans = trans;
    hwrite = wr;
    hsize  = size;
    hburst = burst;
    haddr  = addr;
    hready = rdy;
  endtask

  task automatic drv_idle();
    drv(1'b1, HT_IDLE, 1'b0, 3'd2, HB_SINGLE, 32'h0, 1'b1);
  endtask

  task automatic do_clear();
    drv_idle();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetn = 1'b0;
    err_clear = 1'b0;
    hwdata = 32'h0;
    drv(1'b0, HT_IDLE, 1'b0, 3'd0, HB_SINGLE, 32'h0, 1'b1);
    repeat (2) step();
    checks++; if (err_pulse !== '0) begin errors++; $display("FAIL reset_pulse: got %b exp 0", err_pulse); end
    checks++; if (err_sticky !== '0) begin errors++; $display("FAIL reset_sticky: got %b exp 0", err_sticky); end
    checks++; if (err_first !== 3'd0) begin errors++; $display("FAIL reset_first: got %0d exp 0", err_first); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", err_count); end
    checks++; if (burst_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b exp 0", burst_active); end
    checks++; if (beat_cnt !== 5'd0) begin errors++; $display("FAIL reset_beat: got %0d exp 0", beat_cnt); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_incr4();
    logic [31:0] addrs [4];
    addrs = '{32'h100, 32'h104, 32'h108, 32'h10C};
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, (i == 0) ? HT_NONSEQ : HT_SEQ, 1'b1, 3'd2, HB_INCR4, addrs[i], 1'b1);
      step();
      checks++; if (beat_cnt !== 5'(i + 1)) begin errors++; $display("FAIL incr4_beat%0d: got %0d exp %0d", i, beat_cnt, i + 1); end
      checks++; if (burst_active !== (i < 3)) begin errors++; $display("FAIL incr4_active%0d: got %b exp %b", i, burst_active, (i < 3)); end
      checks++; if (err_pulse !== '0) begin errors++; $display("FAIL incr4_pulse%0d: got %b exp 0", i, err_pulse); end
    end
    drv_idle();
    step();
    checks++; if (beat_cnt !== 5'd0) begin errors++; $display("FAIL incr4_beat_end: got %0d exp 0", beat_cnt); end
  endtask

  task automatic test_wrap4();
    logic [31:0] good [4];
    logic [31:0] bad [4];
    good = '{32'h108, 32'h10C, 32'h100, 32'h104};
    bad  = '{32'h108, 32'h10C, 32'h110, 32'h104};
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, (i == 0) ? HT_NONSEQ : HT_SEQ, 1'b0, 3'd2, HB_WRAP4, good[i], 1'b1);
      step();
      checks++; if (err_pulse !== '0) begin errors++; $display("FAIL wrap4_ok_pulse%0d: got %b exp 0", i, err_pulse); end
    end
    drv_idle();
    step();
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, (i == 0) ? HT_NONSEQ : HT_SEQ, 1'b0, 3'd2, HB_WRAP4, bad[i], 1'b1);
      step();
      if (i == 2) begin
        checks++; if (err_pulse !== NCHK'(1 << CHK_ADDR_SEQ)) begin errors++; $display("FAIL wrap4_bad_pulse: got %b exp %b", err_pulse, NCHK'(1 << CHK_ADDR_SEQ)); end
        checks++; if (err_first !== 3'd2) begin errors++; $display("FAIL wrap4_bad_first: got %0d exp 2", err_first); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL wrap4_bad_count: got %0d exp 1", err_count); end
      end else begin
        checks++; if (err_pulse !== '0) begin errors++; $display("FAIL wrap4_bad_other%0d: got %b exp 0", i, err_pulse); end
      end
    end
    drv_idle();
    step();
  endtask

  task automatic test_timeout();
    do_clear();
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL clear_count: got %0d exp 0", err_count); end
    drv(1'b1, HT_NONSEQ, 1'b1, 3'd2, HB_SINGLE, 32'h300, 1'b1);
    step();
    drv(1'b1, HT_IDLE, 1'b0, 3'd2, HB_SINGLE, 32'h0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++;
      if (err_pulse !== ((k == 17) ? NCHK'(1) : NCHK'(0))) begin
        errors++; $display("FAIL timeout_stall%0d: got %b exp %b", k, err_pulse, (k == 17) ? NCHK'(1) : NCHK'(0));
      end
    end
    hready = 1'b1;
    step();
    checks++; if (err_pulse !== '0) begin errors++; $display("FAIL timeout_release: got %b exp 0", err_pulse); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL timeout_count: got %0d exp 1", err_count); end
    checks++; if (err_sticky !== NCHK'(1)) begin errors++; $display("FAIL timeout_sticky: got %b exp 1", err_sticky); end
  endtask

  task automatic test_ctrl_stable();
    do_clear();
    drv(1'b1, HT_NONSEQ, 1'b0, 3'd2, HB_SINGLE, 32'h1F0, 1'b1);
    step();
    drv(1'b1, HT_NONSEQ, 1'b0, 3'd2, HB_SINGLE, 32'h200, 1'b0);
    step();
    checks++; if (err_pulse !== '0) begin errors++; $display("FAIL ctrl_hold_first: got %b exp 0", err_pulse); end
    haddr = 32'h204;
    step();
    checks++; if (err_pulse !== NCHK'(1 << CHK_CTRL_STABLE)) begin errors++; $display("FAIL ctrl_change: got %b exp %b", err_pulse, NCHK'(1 << CHK_CTRL_STABLE)); end
    hready = 1'b1;
    step();
    checks++; if (err_pulse !== '0) begin errors++; $display("FAIL ctrl_accept: got %b exp 0", err_pulse); end
    drv(1'b1, HT_NONSEQ, 1'b0, 3'd2, HB_INCR8, 32'h400, 1'b1);
    step();
    drv(1'b1, HT_SEQ, 1'b0, 3'd2, HB_INCR8, 32'h404, 1'b1);
    step();
    haddr = 32'h408;
    step();
    checks++; if (beat_cnt !== 5'd3) begin errors++; $display("FAIL incr8_beats: got %0d exp 3", beat_cnt); end
    drv(1'b1, HT_NONSEQ, 1'b0, 3'd2, HB_SINGLE, 32'h500, 1'b1);
    step();
    checks++; if (err_pulse !== NCHK'(1 << CHK_BURST_LEN)) begin errors++; $display("FAIL incr8_short: got %b exp %b", err_pulse, NCHK'(1 << CHK_BURST_LEN)); end
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL incr8_count: got %0d exp 2", err_count); end
    checks++; if (err_first !== 3'd3) begin errors++; $display("FAIL incr8_first: got %0d exp 3", err_first); end
    drv_idle();
    step();
  endtask

  task automatic test_seq_no_burst();
    do_clear();
    drv(1'b1, HT_SEQ, 1'b0, 3'd2, HB_INCR, 32'h600, 1'b1);
    step();
    checks++; if (err_pulse !== NCHK'(1 << CHK_SEQ_NO_BURST)) begin errors++; $display("FAIL seq_idle_pulse: got %b exp %b", err_pulse, NCHK'(1 << CHK_SEQ_NO_BURST)); end
    checks++; if (err_first !== 3'd1) begin errors++; $display("FAIL seq_idle_first: got %0d exp 1", err_first); end
    drv_idle();
    step();
    drv(1'b1, HT_SEQ, 1'b0, 3'd2, HB_INCR, 32'h610, 1'b1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    checks++; if (err_sticky !== NCHK'(5'b00010)) begin errors++; $display("FAIL clear_pulse_sticky: got %b exp 00010", err_sticky); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL clear_pulse_count: got %0d exp 1", err_count); end
    checks++; if (err_first !== 3'd1) begin errors++; $display("FAIL clear_pulse_first: got %0d exp 1", err_first); end
    drv_idle();
    step();
  endtask

  task automatic test_xdata();
    do_clear();
    drv(1'b1, HT_NONSEQ, 1'b1, 3'd2, HB_SINGLE, 32'h800, 1'b1);
    step();
    drv_idle();
    hwdata = 32'hxxxx_0000;
    step();
`ifdef AHB_MON_XCHK_EN
    checks++; if (err_pulse !== NCHK'(1 << CHK_XDATA)) begin errors++; $display("FAIL xdata_pulse: got %b exp %b", err_pulse, NCHK'(1 << CHK_XDATA)); end
`else
    checks++; if (err_pulse !== '0) begin errors++; $display("FAIL xdata_pulse: got %b exp 0", err_pulse); end
`endif
    hwdata = 32'h0;
    step();
  endtask

  task automatic test_reset_mid_burst();
    drv(1'b1, HT_NONSEQ, 1'b0, 3'd2, HB_INCR4, 32'h700, 1'b1);
    step();
    drv(1'b1, HT_SEQ, 1'b0, 3'd2, HB_INCR4, 32'h704, 1'b1);
    step();
    checks++; if (burst_active !== 1'b1) begin errors++; $display("FAIL midburst_active: got %b exp 1", burst_active); end
    resetn = 1'b0;
    #2;
    checks++; if (burst_active !== 1'b0) begin errors++; $display("FAIL async_active: got %b exp 0", burst_active); end
    checks++; if (beat_cnt !== 5'd0) begin errors++; $display("FAIL async_beat: got %0d exp 0", beat_cnt); end
    checks++; if (err_sticky !== '0) begin errors++; $display("FAIL async_sticky: got %b exp 0", err_sticky); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL async_count: got %0d exp 0", err_count); end
    step();
    resetn = 1'b1;
    drv_idle();
    step();
    step();
    checks++; if (err_pulse !== '0) begin errors++; $display("FAIL post_reset_pulse: got %b exp 0", err_pulse); end
    checks++; if (err_sticky !== '0) begin errors++; $display("FAIL post_reset_sticky: got %b exp 0", err_sticky); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_incr4();
    test_wrap4();
    test_timeout();
    test_ctrl_stable();
    test_seq_no_burst();
    test_xdata();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
